mem_arbiter: RTL and testbench

Two-port request arbiter that sits directly upstream of `cache` and drives its RECEIVE_* request port and SEND_* response port. It accepts read or write requests from two independent requesters (port 0: instruction/packet fetch, port 1: load/store), issues one at a time to the cache, and records the granted port in an in-order tag FIFO. Each cache response is routed back to the port that issued the matching request. The cache returns exactly one response per request (read data, or a write acknowledge), in request order.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port request arbiter in front of the cache: one request in flight at a time, in-order tag FIFO routes responses.
// Optional macro MEM_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority (port 0 first).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  P0_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] P0_ADDR,
  input  logic                  P0_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P0_DATA,
  output logic                  P0_READY,
  output logic                  P0_SEND_VALID,
  output logic [DATA_WIDTH-1:0] P0_SEND_DATA,
  input  logic                  P0_SEND_READY,
  input  logic                  P1_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] P1_ADDR,
  input  logic                  P1_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P1_DATA,
  output logic                  P1_READY,
  output logic                  P1_SEND_VALID,
  output logic [DATA_WIDTH-1:0] P1_SEND_DATA,
  input  logic                  P1_SEND_READY,
  output logic                  C_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] C_ADDR,
  output logic                  C_DATA_VALID,
  output logic [DATA_WIDTH-1:0] C_DATA,
  input  logic                  C_READY,
  input  logic                  C_SEND_VALID,
  input  logic [DATA_WIDTH-1:0] C_SEND_DATA,
  output logic                  C_SEND_READY,
  output logic                  ERR
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W + 1)'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    req_wr_q;
  logic [DATA_WIDTH-1:0]   req_data_q;
  logic                    tag_mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]          count_q;
  logic                    err_q;
  logic                    fifo_full, fifo_empty, head;
  logic                    winner, accept, push, pop;

  assign fifo_full  = (count_q == CNT_FULL);
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem[rd_ptr_q];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  // Contention goes to the port not granted last; a lone requester always wins.
  assign winner = (P0_ADDR_VALID && P1_ADDR_VALID) ? ~last_grant_q : ~P0_ADDR_VALID;

  always_ff @(posedge CLK) begin
    if (RST)         last_grant_q <= 1'b1;
    else if (accept) last_grant_q <= winner;
  end
`else
  assign winner = ~P0_ADDR_VALID;
`endif

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_full && (P0_ADDR_VALID || P1_ADDR_VALID)) begin
          accept  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (C_READY) state_d = IDLE;
      end
    endcase
  end

  assign push = accept;
  assign pop  = C_SEND_VALID && C_SEND_READY;

  assign P0_READY     = accept && !winner;
  assign P1_READY     = accept &&  winner;
  assign C_ADDR_VALID = (state_q == ISSUE);
  assign C_ADDR       = req_addr_q;
  assign C_DATA_VALID = req_wr_q;
  assign C_DATA       = req_data_q;

  assign P0_SEND_VALID = C_SEND_VALID && !fifo_empty && !head;
  assign P1_SEND_VALID = C_SEND_VALID && !fifo_empty &&  head;
  assign P0_SEND_DATA  = C_SEND_DATA;
  assign P1_SEND_DATA  = C_SEND_DATA;
  assign C_SEND_READY  = !fifo_empty && (head ? P1_SEND_READY : P0_SEND_READY);
  assign ERR           = err_q;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values, independent of block order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      req_wr_q   <= 1'b0;
      req_data_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_addr_q <= winner ? P1_ADDR       : P0_ADDR;
        req_wr_q   <= winner ? P1_DATA_VALID : P0_DATA_VALID;
        req_data_q <= winner ? P1_DATA       : P0_DATA;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
        2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
        default: ;
      endcase
      if (C_SEND_VALID && fifo_empty) err_q <= 1'b1;
    end
  end

  // NOTE: tag storage is deliberately not reset; an entry is only read while count_q says it holds a live tag.
  always_ff @(posedge CLK) begin
    if (push) tag_mem[wr_ptr_q] <= winner;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cache model plus in-order scoreboard checked by an independent monitor.
module tb_mem_arbiter;

  localparam logic [31:0] WACK = 32'hA5A5_0001;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        P0_ADDR_VALID = 1'b0, P0_DATA_VALID = 1'b0, P0_SEND_READY = 1'b1;
  logic [31:0] P0_ADDR = '0, P0_DATA = '0;
  logic        P1_ADDR_VALID = 1'b0, P1_DATA_VALID = 1'b0, P1_SEND_READY = 1'b1;
  logic [31:0] P1_ADDR = '0, P1_DATA = '0;
  logic        P0_READY, P1_READY, P0_SEND_VALID, P1_SEND_VALID;
  logic [31:0] P0_SEND_DATA, P1_SEND_DATA;
  logic        C_ADDR_VALID, C_DATA_VALID, C_SEND_READY, ERR;
  logic [31:0] C_ADDR, C_DATA, C_SEND_DATA;
  logic        C_READY = 1'b1;
  logic        C_SEND_VALID;

  int checks = 0;
  int errors = 0;

  typedef struct { int port; logic [31:0] data; } exp_t;
  exp_t exp_q [$];

  // Cache model state
  logic [31:0] cmem [logic [31:0]];
  logic [31:0] rsp_q [$];
  logic        c_force = 1'b0, rsp_en = 1'b1, rsp_vld = 1'b0;
  logic [31:0] rsp_data = '0;

  assign C_SEND_VALID = c_force | (rsp_en & rsp_vld);
  assign C_SEND_DATA  = rsp_data;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .P0_ADDR_VALID(P0_ADDR_VALID), .P0_ADDR(P0_ADDR), .P0_DATA_VALID(P0_DATA_VALID), .P0_DATA(P0_DATA),
    .P0_READY(P0_READY), .P0_SEND_VALID(P0_SEND_VALID), .P0_SEND_DATA(P0_SEND_DATA), .P0_SEND_READY(P0_SEND_READY),
    .P1_ADDR_VALID(P1_ADDR_VALID), .P1_ADDR(P1_ADDR), .P1_DATA_VALID(P1_DATA_VALID), .P1_DATA(P1_DATA),
    .P1_READY(P1_READY), .P1_SEND_VALID(P1_SEND_VALID), .P1_SEND_DATA(P1_SEND_DATA), .P1_SEND_READY(P1_SEND_READY),
    .C_ADDR_VALID(C_ADDR_VALID), .C_ADDR(C_ADDR), .C_DATA_VALID(C_DATA_VALID), .C_DATA(C_DATA),
    .C_READY(C_READY), .C_SEND_VALID(C_SEND_VALID), .C_SEND_DATA(C_SEND_DATA), .C_SEND_READY(C_SEND_READY),
    .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Handshakes are sampled at the falling edge, i.e. exactly what the DUT sees at the next rising edge.
  always @(negedge CLK) begin
    if (RST) rsp_q.delete();
    else begin
      if (C_SEND_VALID && C_SEND_READY && rsp_q.size() > 0) void'(rsp_q.pop_front());
      if (C_ADDR_VALID && C_READY) begin
        if (C_DATA_VALID) begin
          cmem[C_ADDR] = C_DATA;
          rsp_q.push_back(WACK);
        end else begin
          rsp_q.push_back(cmem.exists(C_ADDR) ? cmem[C_ADDR] : 32'h0);
        end
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    rsp_vld  = (rsp_q.size() > 0);
    rsp_data = rsp_vld ? rsp_q[0] : 32'h0;
  end

  task automatic score(input int p, input logic [31:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL rsp_unexpected actual port %0d data %h required none", p, d);
    end else begin
      e = exp_q.pop_front();
      check("rsp_port", p, e.port);
      check("rsp_data", d, e.data);
    end
  endtask

  always @(negedge CLK) begin
    if (RST === 1'b0) begin
      if (P0_SEND_VALID && P1_SEND_VALID) begin
        checks++;
        errors++;
        $display("FAIL send_onehot actual both valid required one");
      end
      if (P0_SEND_VALID && P0_SEND_READY) score(0, P0_SEND_DATA);
      if (P1_SEND_VALID && P1_SEND_READY) score(1, P1_SEND_DATA);
    end
  end

  task automatic expect_rsp(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a, input logic w, input logic [31:0] d);
    if (p == 0) begin
      P0_ADDR_VALID = v; P0_ADDR = a; P0_DATA_VALID = w; P0_DATA = d;
    end else begin
      P1_ADDR_VALID = v; P1_ADDR = a; P1_DATA_VALID = w; P1_DATA = d;
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic wait_ready(input int p, input string name);
    logic got = 1'b0;
    int   n   = 0;
    while (!got && n < 200) begin
      @(negedge CLK);
      got = (p == 0) ? P0_READY : P1_READY;
      @(posedge CLK); #1;
      n++;
    end
    check(name, got, 1'b1);
  endtask

  task automatic send_req(input int p, input logic [31:0] a, input logic w, input logic [31:0] d);
    drive(p, 1'b1, a, w, d);
    wait_ready(p, "req_accept");
    drive(p, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset(input int cyc);
    RST = 1'b1;
    repeat (cyc) begin @(posedge CLK); #1; end
    RST = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Reset state
    @(negedge CLK);
    check("rst_err", ERR, 1'b0);
    check("rst_c_addr_valid", C_ADDR_VALID, 1'b0);
    check("rst_c_addr", C_ADDR, 32'h0);
    check("rst_c_data_valid", C_DATA_VALID, 1'b0);
    check("rst_c_data", C_DATA, 32'h0);
    check("rst_ready", {P0_READY, P1_READY}, 2'b00);
    check("rst_send_valid", {P0_SEND_VALID, P1_SEND_VALID}, 2'b00);
    check("rst_c_send_ready", C_SEND_READY, 1'b0);
    @(posedge CLK); #1;

    // Single write then read on port 0, with issue latency checked
    expect_rsp(0, WACK);
    send_req(0, 32'h0000_1234, 1'b1, 32'hDEAD_BEEF);
    @(negedge CLK);
    check("issue_valid", C_ADDR_VALID, 1'b1);
    check("issue_addr", C_ADDR, 32'h0000_1234);
    check("issue_wr", C_DATA_VALID, 1'b1);
    check("issue_data", C_DATA, 32'hDEAD_BEEF);
    @(posedge CLK); #1;
    expect_rsp(0, 32'hDEAD_BEEF);
    send_req(0, 32'h0000_1234, 1'b0, 32'h0);
    wait_drain("drain_single");

    // Contention from a fresh last-grant state
    do_reset(1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 8; i++) begin
      expect_rsp(0, WACK);
      expect_rsp(1, WACK);
    end
`else
    for (int i = 0; i < 8; i++) expect_rsp(0, WACK);
    for (int i = 0; i < 8; i++) expect_rsp(1, WACK);
`endif
    fork
      begin
        for (int i = 0; i < 8; i++) send_req(0, 32'h100 + i, 1'b1, 32'h10 + i);
      end
      begin
        for (int i = 0; i < 8; i++) send_req(1, 32'h200 + i, 1'b1, 32'h20 + i);
      end
    join
    wait_drain("drain_contention");

    // Ordering with delayed cache responses
    expect_rsp(0, WACK); send_req(0, 32'h10, 1'b1, 32'h1111_0000);
    expect_rsp(0, WACK); send_req(0, 32'h20, 1'b1, 32'h2222_0000);
    expect_rsp(0, WACK); send_req(0, 32'h30, 1'b1, 32'h3333_0000);
    wait_drain("drain_prefill");
    rsp_en = 1'b0;
    expect_rsp(0, 32'h1111_0000); send_req(0, 32'h10, 1'b0, 32'h0);
    expect_rsp(1, 32'h2222_0000); send_req(1, 32'h20, 1'b0, 32'h0);
    expect_rsp(0, 32'h3333_0000); send_req(0, 32'h30, 1'b0, 32'h0);
    repeat (3) begin @(posedge CLK); #1; end
    check("ord_held", exp_q.size(), 3);
    rsp_en = 1'b1;
    wait_drain("drain_order");

    // FIFO full blocks a fifth request until a pop
    P0_SEND_READY = 1'b0;
    P1_SEND_READY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_rsp(0, WACK);
      send_req(0, 32'h300 + i, 1'b1, 32'hF0 + i);
    end
    expect_rsp(1, WACK);
    drive(1, 1'b1, 32'h3F0, 1'b1, 32'hF5);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check("full_block", P1_READY, 1'b0);
      @(posedge CLK); #1;
    end
    P0_SEND_READY = 1'b1;
    P1_SEND_READY = 1'b1;
    wait_ready(1, "full_accept");
    drive(1, 1'b0, 32'h0, 1'b0, 32'h0);
    wait_drain("drain_full");

    // Port 1 backpressure stalls the cache and keeps port 0's response behind it
    P1_SEND_READY = 1'b0;
    expect_rsp(1, 32'h2222_0000); send_req(1, 32'h20, 1'b0, 32'h0);
    expect_rsp(0, 32'h1111_0000); send_req(0, 32'h10, 1'b0, 32'h0);
    begin
      int n = 0;
      do begin @(negedge CLK); n++; end while (!P1_SEND_VALID && n < 50);
    end
    check("bp_p1_pending", P1_SEND_VALID, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("bp_c_send_ready", C_SEND_READY, 1'b0);
      check("bp_p0_held", P0_SEND_VALID, 1'b0);
      @(posedge CLK); #1;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    P1_SEND_READY = 1'b1;
    wait_drain("drain_bp");

    // Response with nothing outstanding sets a sticky error
    repeat (2) begin @(posedge CLK); #1; end
    c_force = 1'b1;
    @(negedge CLK);
    check("err_c_send_ready", C_SEND_READY, 1'b0);
    check("err_send_valid", {P0_SEND_VALID, P1_SEND_VALID}, 2'b00);
    check("err_not_yet", ERR, 1'b0);
    @(posedge CLK); #1;
    c_force = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check("err_sticky", ERR, 1'b1);
      @(posedge CLK); #1;
    end

    // Reset while a request is stuck in ISSUE
    C_READY = 1'b0;
    send_req(0, 32'h40, 1'b1, 32'h4444_0000);
    @(negedge CLK);
    check("stuck_issue", C_ADDR_VALID, 1'b1);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    C_READY = 1'b1;
    @(negedge CLK);
    check("mid_rst_err", ERR, 1'b0);
    check("mid_rst_c_addr_valid", C_ADDR_VALID, 1'b0);
    check("mid_rst_c_addr", C_ADDR, 32'h0);
    check("mid_rst_fifo_empty", C_SEND_READY, 1'b0);
    @(posedge CLK); #1;

    // Normal traffic resumes after reset
    expect_rsp(1, 32'h1111_0000);
    send_req(1, 32'h10, 1'b0, 32'h0);
    wait_drain("drain_final");
    repeat (3) begin @(posedge CLK); #1; end
    check("final_err", ERR, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
